fifo_flag_ctrl: RTL and testbench
=================================

// Module: fifo_flag_ctrl
// PURPOSE
//  Occupancy/flag controller for the AXI FIFO, directly upstream of the write- and read-side addr_generator instances.
//  Qualifies raw write/read requests into address-enable pulses.
//  Drives the status inputs (full to the write generator, empty to the read generator).
//  Keeps an occupancy count with almost-full/almost-empty flags and sticky overflow/underflow errors.
// PARAMETERS
//  ADDR_WIDTH   5             address width of the FIFO; DEPTH = 2**ADDR_WIDTH entries
//  AF_THRESH    DEPTH-2       o_almost_full asserts when count >= AF_THRESH
//  AE_THRESH    2             o_almost_empty asserts when count <= AE_THRESH
// PORTS
//  i_clk           in   1              clock; all logic on rising edge
//  i_rst_n         in   1              reset, synchronous, active-low
//  i_wr_req        in   1              producer requests a write this cycle
//  i_rd_req        in   1              consumer requests a read this cycle
//  i_err_clr       in   1              clears sticky error flags
//  o_wr_addr_en    out  1              accepted write; to write addr_generator i_addr_en
//  o_rd_addr_en    out  1              accepted read; to read addr_generator i_addr_en
//  o_full          out  1              FIFO full; also to write addr_generator i_status
//  o_empty         out  1              FIFO empty; also to read addr_generator i_status
//  o_almost_full   out  1              count >= AF_THRESH
//  o_almost_empty  out  1              count <= AE_THRESH
//  o_count         out  ADDR_WIDTH+1   current occupancy, 0..DEPTH
//  o_overflow      out  1              sticky: write requested while full
//  o_underflow     out  1              sticky: read requested while empty
// BEHAVIOUR
//  Reset (i_rst_n==0 at a rising edge):
//   - state=ST_EMPTY, o_count=0, o_empty=1, o_almost_empty=1.
//   - o_full=0, o_almost_full=0, o_overflow=0, o_underflow=0.
//   - While i_rst_n==0, o_wr_addr_en and o_rd_addr_en are forced 0 combinationally.
//   - A reset mid-operation discards the occupancy; requests in that cycle are ignored.
//  Acceptance (combinational, from registered flags):
//   - wr_acc = i_wr_req & ~o_full; rd_acc = i_rd_req & ~o_empty.
//   - o_wr_addr_en = wr_acc; o_rd_addr_en = rd_acc; zero latency.
//  Count update on each rising edge:
//   - wr_acc only: count+1. rd_acc only: count-1.
//   - both, or neither: hold.
//  Flags are registered and reflect count after the edge; no extra latency beyond the count register.
//  The count never wraps: saturation is impossible by construction (acceptance gating).
//  FSM (fifo_state_t):
//   - ST_EMPTY  -> ST_NORMAL on wr_acc. Reads are rejected, so a simultaneous read is ignored.
//   - ST_NORMAL -> ST_FULL when count==DEPTH-1 and wr_acc & ~rd_acc.
//   - ST_NORMAL -> ST_EMPTY when count==1 and rd_acc & ~wr_acc.
//   - ST_NORMAL otherwise stays in ST_NORMAL.
//   - ST_FULL   -> ST_NORMAL on rd_acc. Writes are rejected, so a simultaneous write is ignored.
//   - o_full = (state==ST_FULL); o_empty = (state==ST_EMPTY).
//  Errors:
//   - o_overflow sets on i_wr_req & o_full; o_underflow sets on i_rd_req & o_empty.
//   - Both hold until i_err_clr. If i_err_clr and a new error occur in the same cycle, set wins.
//  DEPTH==2**ADDR_WIDTH matches the addr_generator wrap, so pointer wrap needs no handling here.
//  Elaboration checks: AE_THRESH < AF_THRESH <= DEPTH; otherwise $error.
// STRUCTURE
//  Package axi_fifo_pkg holds:
//   - typedef enum logic [1:0] fifo_state_t {ST_EMPTY, ST_NORMAL, ST_FULL}
//   - function depth(addr_width) returning 2**addr_width
//  One sub-module: fifo_occ_counter (up/down counter, width ADDR_WIDTH+1, inc/dec/hold, sync reset).
//  This module holds the FSM, acceptance gating, threshold compares and sticky errors.
// TESTING
//  1. Reset, then idle -> o_empty=1, o_almost_empty=1, o_count=0, both addr_en=0, errors 0.
//  2. 32 back-to-back i_wr_req -> 32 o_wr_addr_en pulses; o_almost_full at count 30; o_full=1 after 32nd edge.
//     A 33rd request gives o_wr_addr_en=0 and o_overflow=1.
//  3. From full, i_wr_req=i_rd_req=1 for 1 cycle -> rd_addr_en=1, wr_addr_en=0; count=31, o_full=0.
//  4. From count=5, simultaneous wr+rd for 10 cycles -> count stays 5 and both addr_en=1 every cycle.
//  5. Empty, i_rd_req=1 -> o_rd_addr_en=0, o_underflow=1.
//     i_err_clr pulse -> o_underflow=0 next cycle. i_err_clr with i_rd_req held -> o_underflow stays 1.
//  6. Count=17, assert i_rst_n=0 for 1 cycle with i_wr_req=1 -> o_wr_addr_en=0; after the edge o_count=0, o_empty=1.

Source files
------------

// File: rtl/axi_fifo_pkg.sv
// Shared types and helpers for the AXI FIFO control path.
package axi_fifo_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_NORMAL,
        ST_FULL
    } fifo_state_t;

    function automatic int unsigned depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_occ_counter.sv
// Up/down occupancy counter; simultaneous inc and dec cancel out.
module fifo_occ_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (i_inc && !i_dec) begin
            count_q <= count_q + 1'b1;
        end else if (i_dec && !i_inc) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/fifo_flag_ctrl.sv
// FIFO occupancy/flag controller: qualifies requests into address enables and
// tracks full/empty state, almost flags and sticky overflow/underflow errors.
module fifo_flag_ctrl
    import axi_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned AF_THRESH  = depth(ADDR_WIDTH) - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_req,
    input  logic                  i_rd_req,
    input  logic                  i_err_clr,
    output logic                  o_wr_addr_en,
    output logic                  o_rd_addr_en,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int unsigned DEPTH = depth(ADDR_WIDTH);
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] AF_T  = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_T  = CW'(AE_THRESH);
    localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_thresh_check
        $error("fifo_flag_ctrl: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
    end

    fifo_state_t   state_q, state_d;
    logic          wr_acc, rd_acc;
    logic [CW-1:0] count;
    logic          overflow_q, underflow_q;

    fifo_occ_counter #(
        .WIDTH (CW)
    ) u_occ_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (wr_acc),
        .i_dec   (rd_acc),
        .o_count (count)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (wr_acc) state_d = ST_NORMAL;
            end
            ST_NORMAL: begin
                if (count == LAST && wr_acc && !rd_acc) begin
                    state_d = ST_FULL;
                end else if (count == ONE && rd_acc && !wr_acc) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rd_acc) state_d = ST_NORMAL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Acceptance is gated by the registered flags and forced off during reset.
    always_comb begin
        o_full         = (state_q == ST_FULL);
        o_empty        = (state_q == ST_EMPTY);
        wr_acc         = i_rst_n & i_wr_req & ~o_full;
        rd_acc         = i_rst_n & i_rd_req & ~o_empty;
        o_wr_addr_en   = wr_acc;
        o_rd_addr_en   = rd_acc;
        o_almost_full  = (count >= AF_T);
        o_almost_empty = (count <= AE_T);
        o_count        = count;
        o_overflow     = overflow_q;
        o_underflow    = underflow_q;
    end

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (overflow_q & ~i_err_clr) | (i_wr_req & o_full);
            underflow_q <= (underflow_q & ~i_err_clr) | (i_rd_req & o_empty);
        end
    end

endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// Directed and randomized checks of fifo_flag_ctrl against an occupancy model.
module tb_fifo_flag_ctrl;

    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AF    = 30;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic          err_clr = 1'b0;
    logic          wr_addr_en, rd_addr_en, full, empty, almost_full, almost_empty;
    logic          overflow, underflow;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;
    int m_count = 0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    always #5 clk = ~clk;

    fifo_flag_ctrl #(
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wr_req       (wr_req),
        .i_rd_req       (rd_req),
        .i_err_clr      (err_clr),
        .o_wr_addr_en   (wr_addr_en),
        .o_rd_addr_en   (rd_addr_en),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (almost_full),
        .o_almost_empty (almost_empty),
        .o_count        (count),
        .o_overflow     (overflow),
        .o_underflow    (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (count model=%0d)", tag, obs, exp,
                   m_count);
        end
    endtask

    // One clock: drive at the falling edge, check enables, then check state after the edge.
    task automatic step(input bit rst, input bit wr, input bit rd, input bit clr);
        bit exp_wa, exp_ra;
        @(negedge clk);
        rst_n   = ~rst;
        wr_req  = wr;
        rd_req  = rd;
        err_clr = clr;
        #1;
        exp_wa = !rst && wr && (m_count < DEPTH);
        exp_ra = !rst && rd && (m_count > 0);
        check("wr_addr_en", 32'(wr_addr_en), 32'(exp_wa));
        check("rd_addr_en", 32'(rd_addr_en), 32'(exp_ra));
        @(posedge clk);
        #1;
        if (rst) begin
            m_count = 0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            m_ovf   = (m_ovf && !clr) || (wr && m_count == DEPTH);
            m_udf   = (m_udf && !clr) || (rd && m_count == 0);
            m_count = m_count + int'(exp_wa) - int'(exp_ra);
        end
        check("count",        32'(count),        32'(m_count));
        check("full",         32'(full),         32'(m_count == DEPTH));
        check("empty",        32'(empty),        32'(m_count == 0));
        check("almost_full",  32'(almost_full),  32'(m_count >= AF));
        check("almost_empty", 32'(almost_empty), 32'(m_count <= AE));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_udf));
    endtask

    initial begin
        int wr_bias, rd_bias;

        // Reset and idle.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Fill completely, then one extra write to provoke overflow.
        for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 0, 0);
        check("full_after_fill", 32'(full), 32'd1);
        check("overflow_set", 32'(overflow), 32'd1);

        // From full, simultaneous write and read: only the read is accepted.
        step(0, 1, 1, 0);
        check("count_after_full_wr_rd", 32'(count), 32'd31);

        // Drain to empty, clearing the overflow on the way.
        step(0, 0, 1, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);

        // Underflow, clear, then clear with the read still held.
        step(0, 0, 1, 0);
        check("underflow_set", 32'(underflow), 32'd1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        check("underflow_set_wins", 32'(underflow), 32'd1);
        step(0, 0, 0, 1);

        // Hold at count 5 with simultaneous write and read.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0);
        check("count_hold_5", 32'(count), 32'd5);

        // Reset mid-operation at count 17 with a write pending.
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
        check("count_17", 32'(count), 32'd17);
        step(1, 1, 0, 0);
        check("empty_after_reset", 32'(empty), 32'd1);

        // Randomized traffic with phase-varying bias to reach both extremes.
        for (int p = 0; p < 15; p++) begin
            unique case (p % 3)
                0: begin wr_bias = 80; rd_bias = 30; end
                1: begin wr_bias = 30; rd_bias = 80; end
                default: begin wr_bias = 55; rd_bias = 55; end
            endcase
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < wr_bias,
                     $urandom_range(0, 99) < rd_bias,
                     $urandom_range(0, 19) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
